// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 Set-2 receiver/decoder; in clk,rst_n,ps2_clk,ps2_data; out keycode[7:0],extended,key_make,key_break,frame_err; PS2_PARITY_CHECK_EN enables odd-parity check
module ps2_keycode_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       key_make,
  output logic       key_break,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} fstate_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dstate_t;
  logic [1:0] clk_sync, data_sync;
  logic filt;
  logic [FW-1:0] fcnt;
  logic data_s, fall, timeout, byte_ok, ferr_n, ign;
  fstate_t fs, fs_n;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] sh, sh_n;
  logic par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  dstate_t ds, ds_n;
  logic [7:0] kc_n;
  logic ext_n, make_n, brk_n;
  assign data_s = data_sync[1];
  assign fall = filt && !clk_sync[1] && fcnt == FW'(FILTER_LEN - 1);
  assign ign = sh == 8'h00 || sh == 8'hAA || sh == 8'hEE || sh == 8'hFA || sh == 8'hFE || sh == 8'hFF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      fcnt      <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      if (clk_sync[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  always_comb begin
    fs_n    = fs;
    bcnt_n  = bcnt;
    sh_n    = sh;
    par_n   = par;
    ferr_n  = 1'b0;
    byte_ok = 1'b0;
    timeout = fs != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
    tcnt_n  = (fs == IDLE || fall) ? '0 : tcnt + 1'b1;
    if (timeout) begin
      fs_n   = IDLE;
      ferr_n = 1'b1;
      tcnt_n = '0;
    end else if (fall)
      case (fs)
        IDLE: if (!data_s) begin
          fs_n   = DATA;
          bcnt_n = 3'd0;
        end
        DATA: begin
          sh_n   = {data_s, sh[7:1]};
          bcnt_n = bcnt + 3'd1;
          fs_n   = bcnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_n = data_s;
          fs_n  = STOP;
        end
        default: begin
          fs_n    = IDLE;
          byte_ok = data_s && (!PAR_EN || ^{sh, par});
          ferr_n  = !byte_ok;
        end
      endcase
  end
  always_comb begin
    ds_n   = ds;
    kc_n   = keycode;
    ext_n  = extended;
    make_n = 1'b0;
    brk_n  = 1'b0;
    if (timeout) ds_n = D_IDLE;
    else if (byte_ok) begin
      if (sh == 8'hE1) ds_n = D_IDLE;
      else if (ds == D_BRK || ds == D_EXT_BRK) begin
        ds_n = D_IDLE;
        if (sh != 8'hE0 && sh != 8'hF0) begin
          brk_n = 1'b1;
          if (sh == keycode && (ds == D_EXT_BRK) == extended) begin
            kc_n  = 8'h00;
            ext_n = 1'b0;
          end
        end
      end else if (sh == 8'hE0) ds_n = D_EXT;
      else if (sh == 8'hF0) ds_n = ds == D_EXT ? D_EXT_BRK : D_BRK;
      else if (!(ds == D_IDLE && ign)) begin
        kc_n   = sh;
        ext_n  = ds == D_EXT;
        make_n = 1'b1;
        ds_n   = D_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fs        <= IDLE;
      bcnt      <= '0;
      sh        <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      ds        <= D_IDLE;
      keycode   <= 8'h00;
      extended  <= 1'b0;
      key_make  <= 1'b0;
      key_break <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      fs        <= fs_n;
      bcnt      <= bcnt_n;
      sh        <= sh_n;
      par       <= par_n;
      tcnt      <= tcnt_n;
      ds        <= ds_n;
      keycode   <= kc_n;
      extended  <= ext_n;
      key_make  <= make_n;
      key_break <= brk_n;
      frame_err <= ferr_n;
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed self-checking bench for ps2_keycode_rx
module tb_ps2_keycode_rx;
  localparam int TO = 2000;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] keycode;
  logic extended, key_make, key_break, frame_err;
  int n_cmp = 0, n_bad = 0;
  int n_make = 0, n_brk = 0, n_err = 0;
  int m0, b0, e0;
  ps2_keycode_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .extended(extended), .key_make(key_make),
    .key_break(key_break), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (key_make) n_make++;
    if (key_break) n_brk++;
    if (frame_err) n_err++;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_out(input logic b, input logic g);
    ps2_data = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(4);
    if (g) begin
      ps2_clk = 1'b0;
      cyc(1);
      ps2_clk = 1'b1;
    end
    cyc(6);
  endtask
  task automatic send(input logic [7:0] b, input logic bad_stop, input logic bad_par, input logic g);
    bit_out(1'b0, g);
    for (int i = 0; i < 8; i++) bit_out(b[i], g);
    bit_out(bad_par ? ^b : ~^b, g);
    bit_out(!bad_stop, 1'b0);
    ps2_data = 1'b1;
    cyc(20);
  endtask
  task automatic snap;
    m0 = n_make;
    b0 = n_brk;
    e0 = n_err;
  endtask
  task automatic test_reset;
    cyc(5);
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL reset_keycode got %h want 00", keycode); end
    n_cmp++; if (extended !== 1'b0) begin n_bad++; $display("FAIL reset_extended got %b want 0", extended); end
    n_cmp++; if ({key_make, key_break, frame_err} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {key_make, key_break, frame_err}); end
    rst_n = 1'b1;
    cyc(10);
  endtask
  task automatic test_ext_make_break;
    snap();
    send(8'hE0, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    n_cmp++; if (keycode !== 8'h75) begin n_bad++; $display("FAIL ext_make_keycode got %h want 75", keycode); end
    n_cmp++; if (extended !== 1'b1) begin n_bad++; $display("FAIL ext_make_extended got %b want 1", extended); end
    n_cmp++; if (n_make - m0 !== 1) begin n_bad++; $display("FAIL ext_make_pulses got %0d want 1", n_make - m0); end
    snap();
    send(8'hE0, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    n_cmp++; if (keycode !== 8'h00) begin n_bad++; $display("FAIL ext_break_keycode got %h want 00", keycode); end
    n_cmp++; if (extended !== 1'b0) begin n_bad++; $display("FAIL ext_break_extended got %b want 0", extended); end
    n_cmp++; if (n_brk - b0 !== 1) begin n_bad++; $display("FAIL ext_break_pulses got %0d want 1", n_brk - b0); end
    n_cmp++; if (n_make - m0 !== 0) begin n_bad++; $display("FAIL ext_break_make got %0d want 0", n_make - m0); end
  endtask
  task automatic test_last_make;
    send(8'h6B, 0, 0, 0);
    n_cmp++; if (keycode !== 8'h6B) begin n_bad++; $display("FAIL last_make_6b got %h want 6b", keycode); end
    send(8'h74, 0, 0, 0);
    n_cmp++; if (keycode !== 8'h74) begin n_bad++; $display("FAIL last_make_74 got %h want 74", keycode); end
    snap();
    send(8'hF0, 0, 0, 0);
    send(8'h6B, 0, 0, 0);
    n_cmp++; if (keycode !== 8'h74) begin n_bad++; $display("FAIL stale_break_keycode got %h want 74", keycode); end
    n_cmp++; if (n_brk - b0 !== 1) begin n_bad++; $display("FAIL stale_break_pulses got %0d want 1", n_brk - b0); end
  endtask
  task automatic test_bad_stop;
    snap();
    send(8'h72, 1, 0, 0);
    n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL bad_stop_err got %0d want 1", n_err - e0); end
    n_cmp++; if (keycode !== 8'h74) begin n_bad++; $display("FAIL bad_stop_keycode got %h want 74", keycode); end
  endtask
  task automatic test_timeout;
    snap();
    bit_out(1'b0, 0);
    for (int i = 0; i < 3; i++) bit_out(1'b1, 0);
    cyc(TO + 100);
    n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL timeout_err got %0d want 1", n_err - e0); end
    send(8'h72, 0, 0, 0);
    n_cmp++; if (keycode !== 8'h72) begin n_bad++; $display("FAIL timeout_recover got %h want 72", keycode); end
  endtask
  task automatic test_parity;
    snap();
    send(8'h75, 0, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
    n_cmp++; if (keycode !== 8'h72) begin n_bad++; $display("FAIL parity_keycode got %h want 72", keycode); end
    n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL parity_err got %0d want 1", n_err - e0); end
`else
    n_cmp++; if (keycode !== 8'h75) begin n_bad++; $display("FAIL parity_keycode got %h want 75", keycode); end
    n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL parity_err got %0d want 0", n_err - e0); end
`endif
  endtask
  task automatic test_back_to_back;
    send(8'hE0, 0, 0, 0);
    send(8'h74, 0, 0, 0);
    n_cmp++; if ({extended, keycode} !== 9'h174) begin n_bad++; $display("FAIL b2b_make got %h want 174", {extended, keycode}); end
    snap();
    send(8'hF0, 0, 0, 0);
    send(8'h74, 0, 0, 0);
    n_cmp++; if ({extended, keycode} !== 9'h174) begin n_bad++; $display("FAIL b2b_plain_break got %h want 174", {extended, keycode}); end
    n_cmp++; if (n_brk - b0 !== 1) begin n_bad++; $display("FAIL b2b_plain_break_pulse got %0d want 1", n_brk - b0); end
    snap();
    send(8'hAA, 0, 0, 0);
    n_cmp++; if (n_make - m0 !== 0 || keycode !== 8'h74) begin n_bad++; $display("FAIL b2b_ignore got %0d/%h want 0/74", n_make - m0, keycode); end
    send(8'hE0, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h74, 0, 0, 0);
    n_cmp++; if ({extended, keycode} !== 9'h000) begin n_bad++; $display("FAIL b2b_ext_break got %h want 000", {extended, keycode}); end
  endtask
  task automatic test_glitch;
    snap();
    send(8'h6B, 0, 0, 1);
    n_cmp++; if (keycode !== 8'h6B) begin n_bad++; $display("FAIL glitch_keycode got %h want 6b", keycode); end
    n_cmp++; if (n_make - m0 !== 1 || n_err - e0 !== 0) begin n_bad++; $display("FAIL glitch_pulses got %0d/%0d want 1/0", n_make - m0, n_err - e0); end
  endtask
  task automatic test_reset_mid;
    send(8'hE0, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    n_cmp++; if ({extended, keycode} !== 9'h175) begin n_bad++; $display("FAIL rst_pre got %h want 175", {extended, keycode}); end
    bit_out(1'b0, 0);
    for (int i = 0; i < 4; i++) bit_out(1'b0, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({extended, keycode} !== 9'h000) begin n_bad++; $display("FAIL rst_mid got %h want 000", {extended, keycode}); end
    cyc(5);
    rst_n = 1'b1;
    cyc(10);
    snap();
    send(8'h74, 0, 0, 0);
    n_cmp++; if ({extended, keycode} !== 9'h074) begin n_bad++; $display("FAIL rst_recover got %h want 074", {extended, keycode}); end
    n_cmp++; if (n_make - m0 !== 1) begin n_bad++; $display("FAIL rst_recover_make got %0d want 1", n_make - m0); end
  endtask
  initial begin
    test_reset();
    test_ext_make_break();
    test_last_make();
    test_bad_stop();
    test_timeout();
    test_parity();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

PS/2 keyboard receiver and scan-code decoder: deserializes device-to-host frames from the raw PS/2 clock/data lines, then interprets Set-2 E0/F0 prefixes. It presents a level-held `keycode` of the currently pressed key (0x00 when none). It sits between the keyboard pins and the character/motion logic that reads `keycode` (e.g. 0x75 up, 0x72 down, 0x6B left, 0x74 right).

## Interface
- `FILTER_LEN`, 4: consecutive equal synced samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without an accepted falling edge before a partial frame is discarded (1 ms at 50 MHz).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `ps2_clk` input 1: raw PS/2 clock from pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data from pin, asynchronous.
- `keycode` output 8: low byte of currently held key; 0x00 = none.
- `extended` output 1: held key was E0-prefixed; 0 when `keycode` = 0x00.
- `key_make` output 1: one-cycle pulse per decoded make code, including typematic repeats.
- `key_break` output 1: one-cycle pulse per decoded break code.
- `frame_err` output 1: one-cycle pulse on frame dropped (bad stop, bad parity when enabled, or timeout).

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. Synced clock feeds a saturating filter; filtered level resets to 1. Falling edge = filtered level going 1->0. Synced data is sampled on that cycle.
- Frame FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: edge with data=0 -> DATA, bit count 0. Edge with data=1 is ignored.
  - DATA: shift in 8 bits LSB first; after 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: capture bit -> IDLE. Stop=1 (and parity OK, see Configuration) delivers the byte to the decoder; otherwise `frame_err` pulses and the byte is discarded.
- Timeout counter: cleared on every accepted edge and in IDLE. In any non-IDLE state, reaching `TIMEOUT_CYCLES`-1 -> IDLE, `frame_err` pulse, decoder prefix state cleared. An edge arriving on the same cycle as a timeout wins: no timeout, edge processed.
- Decoder FSM states D_IDLE, D_EXT, D_BRK, D_EXT_BRK:
  - E0 in D_IDLE -> D_EXT.
  - F0 in D_IDLE -> D_BRK; F0 in D_EXT -> D_EXT_BRK.
  - Any other byte is a code. In D_IDLE/D_EXT it is a make: `keycode` <= byte, `extended` <= (state==D_EXT), `key_make` pulses. In D_BRK/D_EXT_BRK it is a break: `key_break` pulses; if byte==`keycode` and ext flag==`extended`, `keycode` <= 0x00 and `extended` <= 0; otherwise held key unchanged. State -> D_IDLE.
  - Ignored in D_IDLE (no pulse, state unchanged): 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF. E1 in any state -> D_IDLE, no output.
  - E0 or F0 received in D_BRK or D_EXT_BRK -> D_IDLE, no output.
- Last-make-wins: a new make while a key is held replaces `keycode`.

## Timing
- Reset values: all outputs 0, `keycode` 0x00, both FSMs idle, filtered clock 1, counters 0. Reset mid-frame discards partial data immediately (async).
- Edge detection latency: 2 (sync) + `FILTER_LEN` cycles after the raw `ps2_clk` fall.
- Outputs (`keycode`, `extended`, pulses) update on the `clk` edge following detection of the stop-bit edge. Pulses are high for exactly one cycle.
- No backpressure: every delivered byte is consumed in one cycle; bytes are at least ~60 µs apart on the wire.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity over 8 data bits + parity bit is checked in STOP. A mismatch drops the byte and pulses `frame_err`.
- Undefined: parity bit is captured but ignored; only stop-bit and timeout errors pulse `frame_err`.

## Test plan
- Frames E0,75 -> `keycode`=0x75, `extended`=1, one `key_make` pulse. Then E0,F0,75 -> `keycode`=0x00, `extended`=0, one `key_break` pulse.
- Make 6B, then make 74, then break F0,6B -> `keycode` 0x6B, then 0x74, then stays 0x74 with `key_break` pulse.
- Frame with stop bit 0 carrying 0x72 -> `frame_err` pulse, `keycode` unchanged.
- Start bit plus 3 data bits, then line idle `TIMEOUT_CYCLES` -> `frame_err` pulse, FSM IDLE. Next full 0x72 frame -> `keycode`=0x72.
- 0x75 frame with wrong parity -> with `PS2_PARITY_CHECK_EN`: dropped and `frame_err` pulse; without: `keycode`=0x75.
- 1-cycle glitch lows on `ps2_clk` (shorter than `FILTER_LEN`) mid-frame -> no extra bits. Assert `rst_n`=0 mid-frame -> all outputs 0 at once; next clean frame decodes correctly.
